// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: 640x480@60 timing, pixel fetch via x/y with a 1-cycle pattern
// generator, latency-aligned sync/blanking, and frame-synchronous test-pattern scheduling.
module vga_scan_ctrl #(
  parameter int unsigned H_VIS              = 640,
  parameter int unsigned H_FP               = 16,
  parameter int unsigned H_SYNC             = 96,
  parameter int unsigned H_BP               = 48,
  parameter int unsigned V_VIS              = 480,
  parameter int unsigned V_FP               = 10,
  parameter int unsigned V_SYNC             = 2,
  parameter int unsigned V_BP               = 33,
  parameter bit          SYNC_POL           = 1'b0,
  parameter int unsigned FRAMES_PER_PATTERN = 60
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic        pattern_auto,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] pixel_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [1:0]  pattern_id,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        video_on,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  localparam int unsigned FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FW-1:0] FPP_LAST = FW'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [0:0] {StManual, StAuto} sched_e;

  logic [9:0]    h_cnt, v_cnt;
  logic          h_end, frame_end;
  logic          visible, hs_raw, vs_raw;
  logic          vis_d1, hs_d1, vs_d1;
  sched_e        state;
  logic [FW-1:0] frame_cnt, cnt_cur;

  assign h_end     = (h_cnt == H_LAST);
  assign frame_end = h_end && (v_cnt == V_LAST);
  assign visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_raw    = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw    = (v_cnt >= VS_START) && (v_cnt < VS_END);

  assign x_pos = visible ? h_cnt : '0;
  assign y_pos = visible ? v_cnt : '0;
  // Counters sit at (0,0) during reset, so the pulse must be masked there.
  assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !vga_rst;

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 1 lines up with pixel_data, stage 2 with the registered RGB.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      vis_d1   <= 1'b0;
      hs_d1    <= 1'b0;
      vs_d1    <= 1'b0;
      hs       <= ~SYNC_POL;
      vs       <= ~SYNC_POL;
      video_on <= 1'b0;
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
    end else begin
      vis_d1   <= visible;
      hs_d1    <= hs_raw;
      vs_d1    <= vs_raw;
      hs       <= hs_d1 ? SYNC_POL : ~SYNC_POL;
      vs       <= vs_d1 ? SYNC_POL : ~SYNC_POL;
      video_on <= vis_d1;
      vga_b    <= vis_d1 ? pixel_data[11:8] : '0;
      vga_g    <= vis_d1 ? pixel_data[7:4]  : '0;
      vga_r    <= vis_d1 ? pixel_data[3:0]  : '0;
    end
  end

  // Entering auto mode counts from zero regardless of stale counter contents.
  assign cnt_cur = (state == StAuto) ? frame_cnt : '0;

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      state      <= StManual;
      frame_cnt  <= '0;
      pattern_id <= '0;
    end else if (frame_end) begin
      if (pattern_auto) begin
        state <= StAuto;
        if (cnt_cur == FPP_LAST) begin
          frame_cnt  <= '0;
          pattern_id <= pattern_id + 2'd1;
        end else begin
          frame_cnt <= cnt_cur + FW'(1);
        end
      end else begin
        state      <= StManual;
        frame_cnt  <= '0;
        pattern_id <= pattern_sel;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full-size instance for line timing and pixel path, shrunken
// instance for frame-level sync and pattern scheduling, both against an arithmetic model.
module tb_vga_scan_ctrl;

  localparam int HV[2]  = '{640, 8};
  localparam int HF[2]  = '{16, 2};
  localparam int HSY[2] = '{96, 3};
  localparam int HB[2]  = '{48, 2};
  localparam int VV[2]  = '{480, 6};
  localparam int VF[2]  = '{10, 2};
  localparam int VSY[2] = '{2, 2};
  localparam int VB[2]  = '{33, 3};
  localparam int POL[2] = '{0, 1};
  localparam int FPP[2] = '{60, 2};

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        fs;
    logic [11:0] rgb;
    logic [1:0]  pat;
  } obs_t;

  logic        vga_clk = 1'b0;
  logic        vga_rst;
  logic        pattern_auto;
  logic [1:0]  pattern_sel;
  logic [11:0] pixel_data;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic [1:0] pat_a, pat_b;
  logic       hs_a, vs_a, von_a, fs_a, hs_b, vs_b, von_b, fs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  obs_t       oa, ob;

  int n_checks = 0;
  int n_fail   = 0;
  int n;                  // cycles since reset release
  logic [11:0] pd_prev;   // pixel_data sampled at the end of cycle n-1
  int   base_m[2];
  int   k_m[2];
  logic [1:0] pat_m[2];

  always #20 vga_clk = ~vga_clk;

  vga_scan_ctrl dut_a (
    .vga_clk(vga_clk), .vga_rst(vga_rst), .pattern_auto(pattern_auto),
    .pattern_sel(pattern_sel), .pixel_data(pixel_data), .x_pos(x_a), .y_pos(y_a),
    .pattern_id(pat_a), .hs(hs_a), .vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .video_on(von_a), .frame_start(fs_a)
  );

  vga_scan_ctrl #(
    .H_VIS(HV[1]), .H_FP(HF[1]), .H_SYNC(HSY[1]), .H_BP(HB[1]),
    .V_VIS(VV[1]), .V_FP(VF[1]), .V_SYNC(VSY[1]), .V_BP(VB[1]),
    .SYNC_POL(1'b1), .FRAMES_PER_PATTERN(FPP[1])
  ) dut_b (
    .vga_clk(vga_clk), .vga_rst(vga_rst), .pattern_auto(pattern_auto),
    .pattern_sel(pattern_sel), .pixel_data(pixel_data), .x_pos(x_b), .y_pos(y_b),
    .pattern_id(pat_b), .hs(hs_b), .vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .video_on(von_b), .frame_start(fs_b)
  );

  assign oa = {x_a, y_a, hs_a, vs_a, von_a, fs_a, b_a, g_a, r_a, pat_a};
  assign ob = {x_b, y_b, hs_b, vs_b, von_b, fs_b, b_b, g_b, r_b, pat_b};

  function automatic obs_t model(input int i, input int c, input bit rst_on);
    obs_t e;
    int ht, vt, h, v, h2, v2;
    bit vis2;
    ht = HV[i] + HF[i] + HSY[i] + HB[i];
    vt = VV[i] + VF[i] + VSY[i] + VB[i];
    e = '0;
    e.hs = (POL[i] == 0);
    e.vs = (POL[i] == 0);
    if (rst_on) return e;
    e.pat = pat_m[i];
    h = c % ht;
    v = (c / ht) % vt;
    if (h < HV[i] && v < VV[i]) begin
      e.x = 10'(h);
      e.y = 10'(v);
    end
    e.fs = (h == 0 && v == 0);
    if (c >= 2) begin
      h2 = (c - 2) % ht;
      v2 = ((c - 2) / ht) % vt;
      vis2 = (h2 < HV[i]) && (v2 < VV[i]);
      if (h2 >= HV[i] + HF[i] && h2 < HV[i] + HF[i] + HSY[i]) e.hs = (POL[i] != 0);
      if (v2 >= VV[i] + VF[i] && v2 < VV[i] + VF[i] + VSY[i]) e.vs = (POL[i] != 0);
      e.von = vis2;
      e.rgb = vis2 ? pd_prev : 12'h000;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_inst(input string nm, input obs_t o, input obs_t e);
    chk({nm, ".x_pos"}, 32'(o.x), 32'(e.x));
    chk({nm, ".y_pos"}, 32'(o.y), 32'(e.y));
    chk({nm, ".hs"}, 32'(o.hs), 32'(e.hs));
    chk({nm, ".vs"}, 32'(o.vs), 32'(e.vs));
    chk({nm, ".video_on"}, 32'(o.von), 32'(e.von));
    chk({nm, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    chk({nm, ".rgb"}, 32'(o.rgb), 32'(e.rgb));
    chk({nm, ".pattern_id"}, 32'(o.pat), 32'(e.pat));
  endtask

  task automatic check_all(input bit rst_on);
    check_inst("a", oa, model(0, n, rst_on));
    check_inst("b", ob, model(1, n, rst_on));
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      base_m[i] = 0;
      k_m[i]    = 0;
      pat_m[i]  = 2'd0;
    end
    pd_prev = 12'h000;
  endtask

  // Check cycle n, drive inputs sampled at its closing edge, advance the model.
  task automatic cycle();
    int ht, vt;
    check_all(1'b0);
    if (n == 5605) begin
      chk("a.x_at_5_7", 32'(x_a), 32'd5);
      chk("a.y_at_5_7", 32'(y_a), 32'd7);
    end
    if (n == 5607) chk("a.rgb_abc", 32'({b_a, g_a, r_a}), 32'h0ABC);
    if (n == 657) chk("a.hs_before", 32'(hs_a), 32'd1);
    if (n == 658) chk("a.hs_first", 32'(hs_a), 32'd0);
    if (n == 5606) pixel_data = 12'hABC;
    else if ($urandom_range(3) == 0) pixel_data = 12'hFFF;
    else pixel_data = 12'($urandom);
    for (int i = 0; i < 2; i++) begin
      ht = HV[i] + HF[i] + HSY[i] + HB[i];
      vt = VV[i] + VF[i] + VSY[i] + VB[i];
      if (n % (ht * vt) == ht * vt - 1) begin
        if (pattern_auto) begin
          k_m[i]++;
          pat_m[i] = 2'((base_m[i] + k_m[i] / FPP[i]) % 4);
        end else begin
          base_m[i] = int'(pattern_sel);
          k_m[i]    = 0;
          pat_m[i]  = pattern_sel;
        end
      end
    end
    pd_prev = pixel_data;
    n++;
    @(negedge vga_clk);
    #1;
  endtask

  task automatic reset_hold(input int cycles);
    vga_rst = 1'b1;
    #1;
    reset_model();
    check_all(1'b1);
    repeat (cycles) begin
      @(negedge vga_clk);
      #1;
      check_all(1'b1);
    end
    @(negedge vga_clk);
    vga_rst = 1'b0;
    n = 0;
    #1;
  endtask

  initial begin
    pattern_auto = 1'b1;
    pattern_sel  = 2'd0;
    pixel_data   = 12'h000;
    n            = 0;
    reset_model();
    reset_hold(3);

    // Auto scheduling from reset, then random mode/selection changes.
    repeat (2000) cycle();
    repeat (4000) begin
      if ($urandom_range(49) == 0) pattern_sel = 2'($urandom);
      if ($urandom_range(199) == 0) pattern_auto = ~pattern_auto;
      cycle();
    end

    // Mid-frame reset, then manual selection and mid-frame mode toggles.
    pattern_auto = 1'b0;
    pattern_sel  = 2'd0;
    reset_hold(2);
    repeat (100) cycle();
    pattern_sel = 2'd2;
    repeat (200) cycle();
    pattern_auto = 1'b1;
    repeat (50) cycle();
    pattern_auto = 1'b0;
    pattern_sel  = 2'd3;
    repeat (100) cycle();
    repeat (3000) begin
      if ($urandom_range(29) == 0) pattern_sel = 2'($urandom);
      if ($urandom_range(149) == 0) pattern_auto = ~pattern_auto;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
